// File: rtl/hash_table_pkg.sv
// Shared hash-table widths, head RAM word layout and the head-table write
// arbiter state encoding.
package hash_table;

    localparam int BUCKET_WIDTH   = 10;
    localparam int HEAD_PTR_WIDTH = 12;

    typedef struct packed {
        logic                      ptr_val;
        logic [HEAD_PTR_WIDTH-1:0] ptr;
    } head_ram_data_t;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } head_wr_arb_state_t;

endpackage

// File: rtl/head_table_wr_arb_rr_arb.sv
// Round-robin selector: grants the first requester at or after ptr_i,
// wrapping to the lowest requester when none lie above the pointer.
module rr_arb #(
    parameter int N  = 2,
    parameter int PW = $clog2(N)
) (
    input  logic [N-1:0]  req_i,
    input  logic [PW-1:0] ptr_i,
    output logic [N-1:0]  grant_o
);

    logic [N-1:0] hi_mask;
    logic [N-1:0] req_hi;
    logic [N-1:0] pick_hi;
    logic [N-1:0] pick_all;

    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_mask
            assign hi_mask[gi] = (PW'(gi) >= ptr_i);
        end
    endgenerate

    // x & -x isolates the lowest set bit, giving a one-hot pick.
    assign req_hi   = req_i & hi_mask;
    assign pick_hi  = req_hi & (~req_hi + N'(1));
    assign pick_all = req_i & (~req_i + N'(1));
    assign grant_o  = (|req_hi) ? pick_hi : pick_all;

endmodule

// File: rtl/head_table_wr_arb.sv
// Head table write-port arbiter: round-robin requester writes, plus a
// full-table clear sweep that owns the port exclusively while it runs.
module head_table_wr_arb
    import hash_table::*;
#(
    parameter int NUM_REQ = 2,
    parameter int A_WIDTH = BUCKET_WIDTH,
    parameter int P_WIDTH = HEAD_PTR_WIDTH
) (
    input  logic                              clk_i,
    input  logic                              rst_i,
    input  logic [NUM_REQ-1:0]                req_valid_i,
    output logic [NUM_REQ-1:0]                req_ready_o,
    input  logic [NUM_REQ-1:0][A_WIDTH-1:0]   req_addr_i,
    input  logic [NUM_REQ-1:0][P_WIDTH-1:0]   req_ptr_i,
    input  logic [NUM_REQ-1:0]                req_ptr_val_i,
    output logic                              wr_en_o,
    output logic [A_WIDTH-1:0]                wr_addr_o,
    output logic [P_WIDTH-1:0]                wr_ptr_o,
    output logic                              wr_ptr_val_o,
    input  logic                              clear_run_i,
    output logic                              clear_busy_o,
    output logic                              clear_done_o
);

    localparam int IW = $clog2(NUM_REQ);

    head_wr_arb_state_t state_q;
    logic [A_WIDTH-1:0] cnt_q;
    logic [IW-1:0]      rr_ptr_q;
    logic [IW-1:0]      rr_ptr_d;
    logic               wr_en_q;
    logic [A_WIDTH-1:0] wr_addr_q;
    logic [P_WIDTH-1:0] wr_ptr_q;
    logic               wr_ptr_val_q;
    logic               busy_q;
    logic               done_q;

    logic [NUM_REQ-1:0] grant;
    logic               grant_ok;
    logic               accept;
    logic [IW-1:0]      grant_idx;
    logic [A_WIDTH-1:0] sel_addr;
    logic [P_WIDTH-1:0] sel_ptr;
    logic               sel_ptr_val;

    rr_arb #(
        .N  (NUM_REQ),
        .PW (IW)
    ) u_rr_arb (
        .req_i   (req_valid_i),
        .ptr_i   (rr_ptr_q),
        .grant_o (grant)
    );

    // busy_q still covers the cycle the final clear write is presented,
    // so requesters stay locked out until the sweep is fully retired.
    assign grant_ok    = rst_i && (state_q == IDLE) && !clear_run_i && !busy_q;
    assign req_ready_o = grant & {NUM_REQ{grant_ok}};
    assign accept      = |req_ready_o;

    always_comb begin
        grant_idx   = '0;
        sel_addr    = '0;
        sel_ptr     = '0;
        sel_ptr_val = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                grant_idx   = IW'(i);
                sel_addr    = req_addr_i[i];
                sel_ptr     = req_ptr_i[i];
                sel_ptr_val = req_ptr_val_i[i];
            end
        end
    end

    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (accept) begin
            rr_ptr_d = (grant_idx == IW'(NUM_REQ - 1)) ? '0 : grant_idx + IW'(1);
        end
    end

    // The clear_run edge itself issues address 0, so the sweep lands on
    // wr_* in the very next cycle and the counter resumes from 1.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            rr_ptr_q     <= '0;
            wr_en_q      <= 1'b0;
            wr_addr_q    <= '0;
            wr_ptr_q     <= '0;
            wr_ptr_val_q <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            wr_en_q  <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            rr_ptr_q <= rr_ptr_d;
            if (clear_run_i) begin
                state_q      <= CLEAR;
                cnt_q        <= A_WIDTH'(1);
                wr_en_q      <= 1'b1;
                wr_addr_q    <= '0;
                wr_ptr_q     <= '0;
                wr_ptr_val_q <= 1'b0;
                busy_q       <= 1'b1;
            end else if (state_q == CLEAR) begin
                cnt_q        <= cnt_q + A_WIDTH'(1);
                wr_en_q      <= 1'b1;
                wr_addr_q    <= cnt_q;
                wr_ptr_q     <= '0;
                wr_ptr_val_q <= 1'b0;
                busy_q       <= 1'b1;
                if (&cnt_q) begin
                    done_q  <= 1'b1;
                    state_q <= IDLE;
                end
            end else if (accept) begin
                wr_en_q      <= 1'b1;
                wr_addr_q    <= sel_addr;
                wr_ptr_q     <= sel_ptr;
                wr_ptr_val_q <= sel_ptr_val;
            end
        end
    end

    assign wr_en_o      = wr_en_q;
    assign wr_addr_o    = wr_addr_q;
    assign wr_ptr_o     = wr_ptr_q;
    assign wr_ptr_val_o = wr_ptr_val_q;
    assign clear_busy_o = busy_q;
    assign clear_done_o = done_q;

endmodule

// File: doc/head_table_wr_arb.md
HEAD_TABLE_WR_ARB -- requirements
Module: head_table_wr_arb

Interface
REQ-001 The block SHALL have parameter NUM_REQ, default 2, giving the number of write requesters (2..8).
REQ-002 The block SHALL have parameter A_WIDTH, default BUCKET_WIDTH, giving the head table address width.
REQ-003 The block SHALL have parameter P_WIDTH, default HEAD_PTR_WIDTH, giving the head pointer width.
REQ-004 The block SHALL have one clock; reset is synchronous and active-low.
REQ-005 clk_i  input  1  clock; all logic on its rising edge.
REQ-006 rst_i  input  1  synchronous reset, active-low.
REQ-007 req_valid_i  input  NUM_REQ  per-requester write request.
REQ-008 req_ready_o  output  NUM_REQ  per-requester grant; at most one bit high.
REQ-009 req_addr_i  input  NUM_REQ x A_WIDTH  bucket address per requester.
REQ-010 req_ptr_i  input  NUM_REQ x P_WIDTH  head pointer to write per requester.
REQ-011 req_ptr_val_i  input  NUM_REQ  pointer-valid bit per requester.
REQ-012 wr_en_o, wr_addr_o, wr_ptr_o, wr_ptr_val_o  output  1/A_WIDTH/P_WIDTH/1  registered head table write port.
REQ-013 clear_run_i  input  1  one-cycle pulse starting a full-table clear.
REQ-014 clear_busy_o  output  1  high while the clear is in progress.
REQ-015 clear_done_o  output  1  one-cycle pulse on the final clear write.

Function
REQ-016 A write SHALL be accepted when req_valid_i[k] and req_ready_o[k] are both high; ready may depend combinationally on valid.
REQ-017 Grants SHALL be issued only in state IDLE, and only when clear_run_i is low.
REQ-018 Arbitration SHALL be round-robin; after a grant to k, priority SHALL move to (k+1) mod NUM_REQ.
REQ-019 With no grant, the priority pointer SHALL hold.
REQ-020 An accepted write SHALL appear on wr_* with wr_en_o high exactly one cycle after acceptance, for exactly one cycle.
REQ-021 In a cycle with no accepted write and no clear write, wr_en_o SHALL be 0; wr_addr_o, wr_ptr_o and wr_ptr_val_o SHALL hold their previous values.
REQ-022 The state machine SHALL have states IDLE and CLEAR.
REQ-023 IDLE -> CLEAR on clear_run_i, loading the clear counter with 0; clear_run_i SHALL win over simultaneous requests.
REQ-024 In CLEAR, each cycle SHALL issue wr_en_o=1, wr_addr_o=counter, wr_ptr_o=0, wr_ptr_val_o=0 (registered, one cycle later), then increment the counter modulo 2^A_WIDTH.
REQ-025 CLEAR -> IDLE after the write to address 2^A_WIDTH-1 is issued; clear_done_o SHALL be high in the same cycle that this write is on wr_*.
REQ-026 clear_run_i while in CLEAR SHALL restart the counter at 0 with no done pulse for the aborted sweep.
REQ-027 clear_busy_o SHALL be high from the cycle after clear_run_i up to and including the clear_done_o cycle.
REQ-028 Latency: with clear_run_i at cycle t, clear writes SHALL appear on cycles t+1 .. t+2^A_WIDTH.
REQ-029 Requester writes SHALL never interleave with clear writes; req_ready_o SHALL be all-zero while clear_busy_o is high.

Reset
REQ-030 When rst_i=0 at a clock edge, the block SHALL go to IDLE with counter=0, priority pointer=0, and all outputs 0.
REQ-031 Reset during CLEAR SHALL abort the sweep with no clear_done_o pulse.

Structure
REQ-032 BUCKET_WIDTH, HEAD_PTR_WIDTH, head_ram_data_t and the new state enum head_wr_arb_state_t SHALL reside in package hash_table.
REQ-033 Round-robin selection SHALL be a sub-module named rr_arb (inputs: request vector and priority pointer; output: one-hot grant).

Verification (NUM_REQ=2, A_WIDTH=4)
REQ-034 req_valid_i=2'b11 held for 4 cycles -> grants 0,1,0,1; wr_addr_o follows each granted req_addr_i one cycle later.
REQ-035 clear_run_i pulse at t -> wr_addr_o=0..15 on t+1..t+16 with ptr=0 and ptr_val=0; clear_done_o only at t+16; busy on t+1..t+16.
REQ-036 clear_run_i together with req_valid_i=2'b01 -> req_ready_o=0; the request is granted at t+17.
REQ-037 clear_run_i again at t+5 during a clear -> sweep restarts at address 0; a single done pulse at t+21.
REQ-038 rst_i=0 at t+8 during a clear -> wr_en_o=0 and busy=0 from t+9; no done pulse; priority pointer=0.
REQ-039 Single requester 1 with addr=0x5, ptr=0x2A, ptr_val=1 -> one write with those values one cycle after acceptance.
